e_mdu: RTL

- Multiply/divide unit in the Execute stage, fed directly by the D→E pipeline register.
- Executes mult/multu/div/divu with fixed multi-cycle latency.
- Services mthi/mtlo writes and mfhi/mflo reads of the architectural HI/LO registers.
- Exports `busy` so D-stage hazard logic stalls any HI/LO-touching instruction while an operation is in flight.

---
 rtl/e_mdu_if.sv | 27 ++
 rtl/e_mdu.sv | 113 +++++++++++
 2 files changed

// File: rtl/e_mdu_if.sv
// Execute-stage MDU bundle: control, operands, HI/LO state and read port.
// slave is the unit itself, master is the pipeline side driving it.
interface e_mdu_if;
  logic        start;
  logic [1:0]  mdu_op;
  logic        hilo_we;
  logic        hilo_sel;
  logic [1:0]  rd_sel;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rdata;

  modport slave (
    input  start, mdu_op, hilo_we, hilo_sel,
    input  rd_sel, rs, rt,
    output busy, hi, lo, rdata
  );

  modport master (
    output start, mdu_op, hilo_we, hilo_sel,
    output rd_sel, rs, rt,
    input  busy, hi, lo, rdata
  );
endinterface

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit owning HI/LO.
// Result is computed at launch and held until the fixed latency expires.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic reset,
  e_mdu_if.slave bus
);

  localparam int MAXC =
    (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [63:0]   res_q;
  logic          res_ok;
  logic [31:0]   hi_q;
  logic [31:0]   lo_q;

  logic        is_div;
  logic        is_uns;
  logic [63:0] sprod;
  logic [63:0] uprod;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] b_safe;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [63:0] res_d;
  logic        ok_d;

  assign is_div = bus.mdu_op[1];
  assign is_uns = bus.mdu_op[0];

  assign sprod = $signed({{32{bus.rs[31]}}, bus.rs})
               * $signed({{32{bus.rt[31]}}, bus.rt});
  assign uprod = {32'd0, bus.rs} * {32'd0, bus.rt};

  // Signed divide via magnitudes so MIN/-1 wraps to MIN cleanly
  assign a_neg  = ~is_uns & bus.rs[31];
  assign b_neg  = ~is_uns & bus.rt[31];
  assign a_mag  = a_neg ? (32'd0 - bus.rs) : bus.rs;
  assign b_mag  = b_neg ? (32'd0 - bus.rt) : bus.rt;
  assign b_safe = (bus.rt == 32'd0) ? 32'd1 : b_mag;
  assign q_mag  = a_mag / b_safe;
  assign r_mag  = a_mag % b_safe;
  assign quo    = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
  assign rem    = a_neg ? (32'd0 - r_mag) : r_mag;

  assign res_d = is_div ? {rem, quo}
               : (is_uns ? uprod : sprod);
  assign ok_d  = ~is_div | (bus.rt != 32'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      res_q  <= '0;
      res_ok <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            res_q  <= res_d;
            res_ok <= ok_d;
            cnt    <= is_div ? CW'(DIV_CYCLES)
                             : CW'(MULT_CYCLES);
            state  <= BUSY;
          end else if (bus.hilo_we) begin
            if (bus.hilo_sel) hi_q <= bus.rs;
            else              lo_q <= bus.rs;
          end
        end
        BUSY: begin
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state <= IDLE;
            if (res_ok) begin
              hi_q <= res_q[63:32];
              lo_q <= res_q[31:0];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = (state == BUSY);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

  always_comb begin
    bus.rdata = '0;
    unique case (bus.rd_sel)
      2'b01:   bus.rdata = hi_q;
      2'b10:   bus.rdata = lo_q;
      default: bus.rdata = '0;
    endcase
  end

endmodule
